// File: rtl/fofb_seq_pkg.sv
// fofb_seq_pkg: state encoding and default counter widths shared by the FOFB cycle sequencer.
package fofb_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int CYC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        CALC   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/fofb_cycle_seq_pos_edge.sv
// pos_edge: rising-edge detector; history resets high so a level already high at reset is not an edge.
module pos_edge (
    input  logic clk,
    input  logic reset,
    input  logic enb,
    input  logic trig_in,
    output logic trig_out
);

    logic prev;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            prev <= 1'b1;
        else if (enb)
            prev <= trig_in;

    assign trig_out = enb & trig_in & ~prev;

endmodule

// File: rtl/fofb_cycle_seq.sv
// fofb_cycle_seq: FOFB read -> calc -> output cycle sequencer with overrun/timeout accounting.
// Optional per-phase watchdog enabled by defining FOFB_SEQ_WATCHDOG_EN.
module fofb_cycle_seq
    import fofb_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int CYC_W = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fa_trig,
    input  logic             enable,
    input  logic [CNT_W-1:0] timeout_cfg,
    output logic             pos_read_start,
    input  logic             pos_read_done,
    output logic             calc_start,
    input  logic             calc_done,
    output logic             dac_wr,
    output logic             busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             err_flag,
    input  logic             err_clr
);

    state_t st, st_nxt;
    logic   trig, expired, ov_evt, to_evt;
    logic   rs_nxt, cs_nxt, dw_nxt;

    pos_edge u_edge (
        .clk      (clk),
        .reset    (reset),
        .enb      (1'b1),
        .trig_in  (fa_trig),
        .trig_out (trig)
    );

`ifdef FOFB_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] wd;

    // Loaded on entry to each wait phase; expiry is flagged in the cycle the count reaches 0.
    always_ff @(posedge clk or posedge reset)
        if (reset)
            wd <= '0;
        else if (rs_nxt || cs_nxt)
            wd <= timeout_cfg;
        else if (busy && wd != '0)
            wd <= wd - CNT_W'(1);

    assign expired = wd <= CNT_W'(1);
`else
    logic unused_cfg;

    assign unused_cfg = ^timeout_cfg;
    assign expired    = 1'b0;
`endif

    assign busy   = st != IDLE;
    assign state  = st;
    assign ov_evt = trig && busy;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            st <= IDLE;
        else
            st <= st_nxt;

    // A done pulse always beats a same-cycle watchdog expiry.
    always_comb begin
        st_nxt = st;
        rs_nxt = 1'b0;
        cs_nxt = 1'b0;
        dw_nxt = 1'b0;
        to_evt = 1'b0;
        case (st)
            IDLE: begin
                rs_nxt = trig && enable;
                st_nxt = rs_nxt ? READ : IDLE;
            end
            READ: begin
                cs_nxt = pos_read_done;
                to_evt = !pos_read_done && expired;
                st_nxt = pos_read_done ? CALC : (expired ? IDLE : READ);
            end
            CALC: begin
                dw_nxt = calc_done;
                to_evt = !calc_done && expired;
                st_nxt = calc_done ? OUTPUT : (expired ? IDLE : CALC);
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pos_read_start <= 1'b0;
            calc_start     <= 1'b0;
            dac_wr         <= 1'b0;
            cycle_cnt      <= '0;
            overrun_cnt    <= '0;
            timeout_cnt    <= '0;
            err_flag       <= 1'b0;
        end else begin
            pos_read_start <= rs_nxt;
            calc_start     <= cs_nxt;
            dac_wr         <= dw_nxt;
            if (st == OUTPUT)
                cycle_cnt <= cycle_cnt + CYC_W'(1);
            overrun_cnt <= err_clr ? '0 :
                           (ov_evt && overrun_cnt != '1) ? overrun_cnt + CNT_W'(1) : overrun_cnt;
            timeout_cnt <= err_clr ? '0 :
                           (to_evt && timeout_cnt != '1) ? timeout_cnt + CNT_W'(1) : timeout_cnt;
            err_flag    <= !err_clr && (err_flag || ov_evt || to_evt);
        end

endmodule

// File: tb/tb_fofb_cycle_seq.sv
// tb_fofb_cycle_seq: directed self-checking bench for fofb_cycle_seq (8-bit error counters, 4-bit cycle counter).
module tb_fofb_cycle_seq;

    logic       clk = 1'b0, reset = 1'b1, fa_trig = 1'b1, enable = 1'b0;
    logic       pos_read_done = 1'b0, calc_done = 1'b0, err_clr = 1'b0;
    logic [7:0] timeout_cfg = 8'd100;
    logic       pos_read_start, calc_start, dac_wr, busy, err_flag;
    logic [1:0] state;
    logic [7:0] overrun_cnt, timeout_cnt;
    logic [3:0] cycle_cnt;

    int n_chk = 0, n_err = 0, n_rs = 0, n_cs = 0, n_dw = 0;
    int e_cyc = 0, e_dw = 0, e_to = 0;

    fofb_cycle_seq #(.CNT_W(8), .CYC_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .fa_trig        (fa_trig),
        .enable         (enable),
        .timeout_cfg    (timeout_cfg),
        .pos_read_start (pos_read_start),
        .pos_read_done  (pos_read_done),
        .calc_start     (calc_start),
        .calc_done      (calc_done),
        .dac_wr         (dac_wr),
        .busy           (busy),
        .state          (state),
        .overrun_cnt    (overrun_cnt),
        .timeout_cnt    (timeout_cnt),
        .cycle_cnt      (cycle_cnt),
        .err_flag       (err_flag),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pos_read_start) n_rs++;
        if (calc_start) n_cs++;
        if (dac_wr) n_dw++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig_edge();
        fa_trig = 1'b0;
        tick();
        fa_trig = 1'b1;
        tick();
    endtask

    task automatic finish_cycle();
        pos_read_done = 1'b1;
        tick();
        pos_read_done = 1'b0;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        tick();
        e_cyc++;
        e_dw++;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {pos_read_start, calc_start, dac_wr}, 0);
        check("rst_counters", {overrun_cnt, timeout_cnt, cycle_cnt, err_flag}, 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("high_level_no_start", state, 0);
        check("high_level_no_pulse", n_rs, 0);

        enable = 1'b0;
        trig_edge();
        check("disabled_state", state, 0);
        check("disabled_ovr", overrun_cnt, 0);

        enable = 1'b1;
        timeout_cfg = 8'd100;
        trig_edge();
        check("read_start", pos_read_start, 1);
        check("read_state", state, 1);
        check("read_busy", busy, 1);
        tick();
        check("read_start_once", pos_read_start, 0);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        check("stray_calc_done", state, 1);
        check("stray_no_dac", dac_wr, 0);
        trig_edge();
        check("ovr_cnt", overrun_cnt, 1);
        check("ovr_err", err_flag, 1);
        check("ovr_state", state, 1);
        fa_trig = 1'b0;
        repeat (10) tick();
        pos_read_done = 1'b1;
        tick();
        pos_read_done = 1'b0;
        check("calc_start", calc_start, 1);
        check("calc_state", state, 2);
        pos_read_done = 1'b1;
        tick();
        pos_read_done = 1'b0;
        check("stray_read_done", state, 2);
        check("calc_start_once", calc_start, 0);
        enable = 1'b0;
        repeat (3) tick();
        check("enable_drop", state, 2);
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        check("dac_wr", dac_wr, 1);
        check("out_state", state, 3);
        fa_trig = 1'b1;
        tick();
        check("out_ovr", overrun_cnt, 2);
        check("out_to_idle", state, 0);
        check("out_dac_once", dac_wr, 0);
        check("cycle_one", cycle_cnt, 1);
        check("single_dac", n_dw, 1);
        e_cyc = 1;
        e_dw = 1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_ovr", overrun_cnt, 0);
        check("clr_err", err_flag, 0);

        enable = 1'b1;
        timeout_cfg = 8'd5;
        trig_edge();
        check("to_read", state, 1);
        repeat (4) tick();
        check("to_hold", state, 1);
        tick();
`ifdef FOFB_SEQ_WATCHDOG_EN
        e_to = 1;
        check("to_idle", state, 0);
        check("to_cnt", timeout_cnt, 1);
        check("to_err", err_flag, 1);
        check("to_no_calc", n_cs, 1);
        timeout_cfg = 8'd0;
        trig_edge();
        check("cfg0_read", state, 1);
        tick();
        e_to = 2;
        check("cfg0_abort", state, 0);
        check("cfg0_cnt", timeout_cnt, 2);
`else
        check("nowd_read", state, 1);
        repeat (200) tick();
        check("nowd_wait", state, 1);
        check("nowd_to_cnt", timeout_cnt, 0);
        finish_cycle();
        check("nowd_done", state, 0);
`endif
        check("cyc_after_to", cycle_cnt, e_cyc % 16);

        timeout_cfg = 8'd3;
        trig_edge();
        tick();
        tick();
        pos_read_done = 1'b1;
        tick();
        pos_read_done = 1'b0;
        check("race_read", state, 2);
        tick();
        tick();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        check("race_dac", dac_wr, 1);
        check("race_out", state, 3);
        check("race_to_cnt", timeout_cnt, e_to);
        tick();
        e_cyc++;
        e_dw++;

        timeout_cfg = 8'd100;
        trig_edge();
        pos_read_done = 1'b1;
        tick();
        pos_read_done = 1'b0;
        trig_edge();
        check("pre_rst_calc", state, 2);
        check("pre_rst_ovr", overrun_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_pulses", {pos_read_start, calc_start, dac_wr}, 0);
        check("async_rst_cnt", {overrun_cnt, timeout_cnt, cycle_cnt, err_flag}, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_no_start", state, 0);
        e_cyc = 0;
        e_to = 0;

        for (int i = 0; i < 17; i++) begin
            trig_edge();
            finish_cycle();
        end
        check("cycle_wrap", cycle_cnt, e_cyc % 16);

        timeout_cfg = 8'd255;
        for (int c = 0; c < 3; c++) begin
            trig_edge();
            for (int k = 0; k < (c < 2 ? 100 : 57); k++) trig_edge();
            if (c < 2) finish_cycle();
        end
        check("ovr_sat", overrun_cnt, 255);
        check("ovr_sat_err", err_flag, 1);
        check("ovr_sat_state", state, 1);
        fa_trig = 1'b0;
        tick();
        fa_trig = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_prio_ovr", overrun_cnt, 0);
        check("clr_prio_err", err_flag, 0);
        finish_cycle();
        check("final_cycle", cycle_cnt, e_cyc % 16);
        check("final_dac_total", n_dw, e_dw);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
